// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Purpose:
//   Shares the register file's single write port between the in-order
//   pipeline writeback stage and a long-latency multi-cycle unit (mul/div).
//   Multi-cycle results are buffered in a small in-order FIFO. They are drained
//   into writeback slots that the pipeline does not use.
//   If the pipeline keeps the FIFO head blocked for MAX_WAIT granted cycles,
//   the pipeline is stalled for one cycle so that the head can drain.
//   Destinations still waiting in the FIFO are reported to the hazard unit.
//
// Parameters:
//   DEPTH    - FIFO entries (power of 2, >= 2)
//   MAX_WAIT - pipeline grants allowed while the FIFO head waits (>= 1)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wb_we_i/wb_rd_i/wb_data_i pipeline writeback request (RegWrite/RdW/ResultW)
//   wb_stall_o                pipeline must hold its WB-stage contents
//   mc_valid_i/mc_rd_i/mc_data_i  multi-cycle result offered to the FIFO
//   mc_ready_o                FIFO can accept a result this cycle
//   rs1_i, rs2_i              decode-stage source registers
//   pend1_o, pend2_o          rs1_i / rs2_i match a queued destination
//   rf_we_o/rf_rd_o/rf_wdata_o register file write port
//   stall_cnt_o, mc_cnt_o     (only with WBARB_STATS_EN) stall-cycle count and
//                             accepted non-x0 result count, wrap on overflow
//
// Configuration:
//   Define WBARB_STATS_EN to add the statistics counters and their ports.
//
// Handshake: a multi-cycle result transfers on a rising edge where
//   mc_valid_i && mc_ready_o. mc_ready_o depends only on the FIFO occupancy
//   and never on a same-cycle dequeue. The producer must hold its
//   mc_rd_i/mc_data_i stable while mc_valid_i is high and mc_ready_o is low.
//   When wb_stall_o is high, the pipeline must present the same WB request
//   again in the next cycle. That request is then granted.
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_we_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   output logic        wb_stall_o,
   input  logic        mc_valid_i,
   input  logic [4:0]  mc_rd_i,
   input  logic [31:0] mc_data_i,
   output logic        mc_ready_o,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   output logic        pend1_o,
   output logic        pend2_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_rd_o,
   output logic [31:0] rf_wdata_o
`ifdef WBARB_STATS_EN
   ,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] mc_cnt_o
`else
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // pointer width
   localparam int CW = $clog2(DEPTH + 1);                 // occupancy width
   localparam int SW = $clog2(MAX_WAIT + 1);              // starve width

   // FIFO storage and control
   logic [4:0]    rdMem   [DEPTH];
   logic [31:0]   dataMem [DEPTH];
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic [CW-1:0] count;
   logic [SW-1:0] starve;

   // Request / grant decode
   logic pipeReq;
   logic qNe;
   logic starveHit;
   logic pipeGrant;
   logic fifoGrant;
   logic enqAccept;
   logic enqWrite;

   logic [DEPTH-1:0] entryValid;
   logic [DEPTH-1:0] match1;
   logic [DEPTH-1:0] match2;

   // ---------------------------------------------------------------------
   // Request and grant. While rst is high, every grant is forced low.
   // The stale FIFO state can then never reach the register file.
   // ---------------------------------------------------------------------
   assign pipeReq   = wb_we_i && (wb_rd_i != 5'd0);
   assign qNe       = (count != '0);
   assign starveHit = qNe && (starve == SW'(MAX_WAIT));

   assign pipeGrant = !rst && pipeReq && !starveHit;
   assign fifoGrant = !rst && !pipeGrant && qNe;

   assign wb_stall_o = !rst && pipeReq && starveHit;

   // mc_ready_o looks only at the occupancy, so a full FIFO refuses a
   // result even in the cycle where the FIFO drains its head.
   assign mc_ready_o = !rst && (count < CW'(DEPTH));
   assign enqAccept  = mc_valid_i && mc_ready_o;
   // A result for x0 completes the handshake but is dropped.
   assign enqWrite   = enqAccept && (mc_rd_i != 5'd0);

   // ---------------------------------------------------------------------
   // Write port mux (combinational pass-through for the pipeline)
   // ---------------------------------------------------------------------
   always_comb begin
      rf_we_o    = 1'b0;
      rf_rd_o    = 5'd0;
      rf_wdata_o = 32'd0;
      if (pipeGrant) begin
         rf_we_o    = 1'b1;
         rf_rd_o    = wb_rd_i;
         rf_wdata_o = wb_data_i;
      end else if (fifoGrant) begin
         rf_we_o    = 1'b1;
         rf_rd_o    = rdMem[rdPtr];
         rf_wdata_o = dataMem[rdPtr];
      end
   end

   // ---------------------------------------------------------------------
   // FIFO storage. Contents need no reset, because the occupancy decides
   // which entries are live.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (enqWrite) begin
         rdMem[wrPtr]   <= mc_rd_i;
         dataMem[wrPtr] <= mc_data_i;
      end
   end

   // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH
   // is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (enqWrite) begin
            wrPtr <= wrPtr + PW'(1);
         end
         if (fifoGrant) begin
            rdPtr <= rdPtr + PW'(1);
         end
         count <= count + CW'(enqWrite) - CW'(fifoGrant);
      end
   end

   // Starvation counter. It counts the pipeline grants that the waiting
   // head has lost. It clears when the head drains or the FIFO is empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve <= '0;
      end else if (fifoGrant || !qNe) begin
         starve <= '0;
      end else if (pipeGrant && (starve != SW'(MAX_WAIT))) begin
         starve <= starve + SW'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Pending-destination lookup. An entry is live when its distance from
   // the read pointer is below the occupancy. The head being dequeued this
   // cycle still counts, because it reaches the register file only at the
   // coming edge.
   // ---------------------------------------------------------------------
   always_comb begin
      entryValid = '0;
      match1     = '0;
      match2     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         entryValid[i] = (CW'(PW'(i) - rdPtr) < count);
         match1[i]     = (rdMem[i] == rs1_i);
         match2[i]     = (rdMem[i] == rs2_i);
      end
   end

   assign pend1_o = !rst && (rs1_i != 5'd0) && |(entryValid & match1);
   assign pend2_o = !rst && (rs2_i != 5'd0) && |(entryValid & match2);

`ifdef WBARB_STATS_EN
   // ---------------------------------------------------------------------
   // Statistics: stall cycles and accepted non-x0 results. Both wrap.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_o <= 32'd0;
         mc_cnt_o    <= 32'd0;
      end else begin
         if (wb_stall_o) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
         end
         if (enqWrite) begin
            mc_cnt_o <= mc_cnt_o + 32'd1;
         end
      end
   end
`else
`endif

endmodule
